// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-drain UART transmitter.
// Optional macro PARITY_EN adds an even-parity state to the frame.
package fifo_uart_pkg;

    localparam int unsigned CNT_W           = 16;
    localparam int unsigned WORD_W          = 16;
    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned BIT_IDX_W       = 3;
    localparam int unsigned WAIT_TIMEOUT    = 3;
    localparam int unsigned WAIT_CNT_W      = 2;
    localparam int unsigned CLK_DIV_DEFAULT = 868;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
`ifdef PARITY_EN
        ST_PARITY = 3'd6,
`endif
        ST_STOP   = 3'd5
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: counts 0..CLK_DIV-1, restarts on clr, flags the last cycle.
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic bit_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // next count: restart on clear or at end of bit period
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (clr || (cnt == LAST)) begin
            cnt_nxt = '0;
        end
    end

    // counter and registered end-of-bit flag (high while cnt == LAST)
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt      <= '0;
            bit_done <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            bit_done <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops 16-bit words from the FIFO read port and sends each as two UART
// frames, low byte first. Define PARITY_EN for 8E1 framing (default 8N1).
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic              FIFO_EMPTY,
    input  logic              FIFO_VALID,
    input  logic [WORD_W-1:0] FIFO_DATA,
    output logic              FIFO_RD,
    output logic              TXD,
    output logic              BUSY,
    output logic              ERR
);

    localparam logic [BIT_IDX_W-1:0]  LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(WAIT_TIMEOUT - 1);

    state_t                  state, state_nxt;
    logic [WORD_W-1:0]       word, word_nxt;
    logic                    byte_sel, byte_sel_nxt;
    logic [BIT_IDX_W-1:0]    bit_idx, bit_idx_nxt, bit_inc_c;
    logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                    rd_nxt, txd_nxt, err_nxt, busy_nxt;
    logic [DATA_BITS-1:0]    cur_byte_c;
    logic                    clr_c;
    logic                    bit_done;

    assign cur_byte_c = byte_sel ? word[WORD_W-1:DATA_BITS] : word[DATA_BITS-1:0];
    assign bit_inc_c  = bit_idx + BIT_IDX_W'(1);
    assign clr_c      = (state_nxt != state);

    uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (clr_c),
        .bit_done (bit_done)
    );

    // state register and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            word     <= '0;
            byte_sel <= 1'b0;
            bit_idx  <= '0;
            wait_cnt <= '0;
            FIFO_RD  <= 1'b0;
            TXD      <= 1'b1;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state    <= state_nxt;
            word     <= word_nxt;
            byte_sel <= byte_sel_nxt;
            bit_idx  <= bit_idx_nxt;
            wait_cnt <= wait_cnt_nxt;
            FIFO_RD  <= rd_nxt;
            TXD      <= txd_nxt;
            BUSY     <= busy_nxt;
            ERR      <= err_nxt;
        end
    end

    // next state; TXD is computed for the state being entered so it lines up
    always_comb begin
        state_nxt    = state;
        word_nxt     = word;
        byte_sel_nxt = byte_sel;
        bit_idx_nxt  = bit_idx;
        wait_cnt_nxt = wait_cnt;
        rd_nxt       = 1'b0;
        err_nxt      = 1'b0;
        txd_nxt      = TXD;

        case (state)
            ST_IDLE: begin
                txd_nxt = 1'b1;
                if (ENABLE && !FIFO_EMPTY) begin
                    state_nxt = ST_REQ;
                    rd_nxt    = 1'b1;
                end
            end
            ST_REQ: begin
                wait_cnt_nxt = '0;
                state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (FIFO_VALID) begin
                    word_nxt     = FIFO_DATA;
                    byte_sel_nxt = 1'b0;
                    state_nxt    = ST_START;
                    txd_nxt      = 1'b0;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_CNT_W'(1);
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_nxt   = ST_DATA;
                    bit_idx_nxt = '0;
                    txd_nxt     = cur_byte_c[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx == LAST_BIT) begin
`ifdef PARITY_EN
                        state_nxt = ST_PARITY;
                        txd_nxt   = ^cur_byte_c;
`else
                        state_nxt = ST_STOP;
                        txd_nxt   = 1'b1;
`endif
                    end else begin
                        bit_idx_nxt = bit_inc_c;
                        txd_nxt     = cur_byte_c[bit_inc_c];
                    end
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_nxt = ST_STOP;
                    txd_nxt   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    if (!byte_sel) begin
                        byte_sel_nxt = 1'b1;
                        state_nxt    = ST_START;
                        txd_nxt      = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                        txd_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                txd_nxt   = 1'b1;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule
